serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
//==============================================================================
// Module      : serial_adder
// Description : Slice-serial adder: WIDTH-bit a+b+cin, SLICE bits per cycle,
//               valid/ready on both sides. Define SERIAL_ADDER_OVF_EN to add
//               the signed-overflow output ovf.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [SLICE-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_ext;
    logic             w_accept;
    logic             w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == C_LAST);

    // Operands shift right so the active slice is always at bit 0; results
    // enter at the top and land in their own slice after NSLICE shifts.
    assign {w_carry, w_res} = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                            + {{SLICE{1'b0}}, r_carry};
    assign w_res_ext = WIDTH'(w_res) << (WIDTH - SLICE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (r_state == RUN) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_sum   <= (r_sum >> SLICE) | w_res_ext;
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
            // a^b^sum at the MSB recovers the carry into the MSB
            if (w_last) begin
                r_ovf <= r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_res[SLICE-1] ^ w_carry;
            end
`endif
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

`default_nettype wire
